// File: rtl/cpu_pkg.sv
// Shared datapath types for the sequential Booth multiplier and its recoder.
// Also carries the ALU opcode that selects the multiply path.
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } mul_state_t;

  typedef enum logic [2:0] {
    B_ZERO,
    B_PM,
    B_P2M,
    B_NM,
    B_N2M
  } booth_op_t;

  localparam logic [3:0] ALU_MUL = 4'd11;

endpackage

// File: rtl/seq_booth_multiplier_if.sv
// Start/busy/done handshake and operand/product bus between control unit and multiplier.
// master = control unit side, slave = multiplier side.
interface seq_booth_multiplier_if #(
  parameter int WIDTH = 32
);

  logic             start;
  logic             signed_mode;
  logic [WIDTH-1:0] multiplicand;
  logic [WIDTH-1:0] multiplier;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, signed_mode, multiplicand, multiplier,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, signed_mode, multiplicand, multiplier,
    output busy, done, hi, lo
  );

endinterface

// File: rtl/booth_r4_recoder.sv
// Radix-4 Booth recoder: maps a 3-bit multiplier window {q[i+1], q[i], q[i-1]}
// onto one of the five partial-product selections.
module booth_r4_recoder
  import cpu_pkg::*;
(
  input  logic [2:0] bits,
  output booth_op_t  op
);

  always_comb begin
    op = B_ZERO;
    unique case (bits)
      3'b000:  op = B_ZERO;
      3'b001:  op = B_PM;
      3'b010:  op = B_PM;
      3'b011:  op = B_P2M;
      3'b100:  op = B_N2M;
      3'b101:  op = B_NM;
      3'b110:  op = B_NM;
      3'b111:  op = B_ZERO;
      default: op = B_ZERO;
    endcase
  end

endmodule

// File: rtl/seq_booth_multiplier.sv
// Multi-cycle radix-4 Booth multiplier, signed or unsigned per operation, full 2*WIDTH product.
// Optional BOOTH_EARLY_TERM_EN: finish as soon as the remaining multiplier bits recode to zero.
//
// state | meaning
// IDLE  | waiting for start, hi/lo hold the last product
// BUSY  | one radix-4 step per clock
// DONE  | product valid on hi/lo for one cycle, start accepted here too
module seq_booth_multiplier
  import cpu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  clear_n,
  seq_booth_multiplier_if.slave bus
);

  localparam int STEPS = WIDTH / 2 + 1;
  localparam int EW    = WIDTH + 2;
  localparam int AW    = WIDTH + 3;
  localparam int QW    = EW + 1;
  localparam int PW    = AW + QW;
  localparam int CW    = $clog2(STEPS + 1);

  generate
    if ((WIDTH % 2) != 0 || WIDTH < 4) begin : g_bad_width
      $error("seq_booth_multiplier: WIDTH must be even and >= 4");
    end
  endgenerate

  mul_state_t       state_q, state_d;
  logic [PW-1:0]    pair_q, pair_d;
  logic [EW-1:0]    mcand_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic             load, finish, early;

  booth_op_t        op;
  logic [AW-1:0]    acc, addend, sum;
  logic [QW-1:0]    qreg;
  logic [EW-1:0]    ext_a, ext_b;

  assign acc  = pair_q[PW-1 -: AW];
  assign qreg = pair_q[QW-1:0];

  assign ext_a = bus.signed_mode ? {{2{bus.multiplicand[WIDTH-1]}}, bus.multiplicand}
                                 : {2'b00, bus.multiplicand};
  assign ext_b = bus.signed_mode ? {{2{bus.multiplier[WIDTH-1]}}, bus.multiplier}
                                 : {2'b00, bus.multiplier};

  booth_r4_recoder u_recoder (
    .bits (qreg[2:0]),
    .op   (op)
  );

  always_comb begin
    addend = '0;
    unique case (op)
      B_PM:    addend = {mcand_q[EW-1], mcand_q};
      B_P2M:   addend = {mcand_q, 1'b0};
      B_NM:    addend = -{mcand_q[EW-1], mcand_q};
      B_N2M:   addend = -{mcand_q, 1'b0};
      default: addend = '0;
    endcase
  end

  assign sum = acc + addend;

`ifdef BOOTH_EARLY_TERM_EN
  logic sign_q;

  // Unconsumed multiplier bits sit in qreg[2*cnt:0]; if they all match the
  // sign, every remaining window recodes to zero and only the shift is left.
  always_comb begin
    early = 1'b1;
    for (int i = 0; i < QW; i++) begin
      if (i <= 2 * int'(cnt_q) && qreg[i] != sign_q) early = 1'b0;
    end
  end

  always_comb begin
    if (early) pair_d = $signed(pair_q) >>> {cnt_q, 1'b0};
    else       pair_d = $signed({sum, qreg}) >>> 2;
  end

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n)  sign_q <= 1'b0;
    else if (load) sign_q <= ext_b[EW-1];
  end
`else
  assign early  = 1'b0;
  assign pair_d = $signed({sum, qreg}) >>> 2;
`endif

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    finish  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = BUSY;
          load    = 1'b1;
        end
      end
      BUSY: begin
        if (early || cnt_q == CW'(1)) begin
          state_d = DONE;
          finish  = 1'b1;
        end
      end
      DONE: begin
        if (bus.start) begin
          state_d = BUSY;
          load    = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The product's bit 0 lands at pair bit 1, just above the spent Q[-1].
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      pair_q  <= '0;
      mcand_q <= '0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else if (load) begin
      pair_q  <= {{AW{1'b0}}, ext_b, 1'b0};
      mcand_q <= ext_a;
      cnt_q   <= CW'(STEPS);
    end else if (state_q == BUSY) begin
      pair_q <= pair_d;
      cnt_q  <= early ? '0 : cnt_q - CW'(1);
      if (finish) begin
        hi_q <= pair_d[2*WIDTH:WIDTH+1];
        lo_q <= pair_d[WIDTH:1];
      end
    end
  end

  assign bus.busy = (state_q == BUSY);
  assign bus.done = (state_q == DONE);
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: doc/seq_booth_multiplier.md
Name: seq_booth_multiplier

Overview:
- Multi-cycle radix-4 Booth multiplier for the datapath ALU. It replaces the single-shot multiply path and is selected by ALU_MUL.
- Parametrised operand width; signed or unsigned mode per operation.
- Start/busy/done handshake with the control unit.
- Full 2*WIDTH product is written to the HI/LO registers; the control unit moves it into Zhigh/Zlow.

Parameters:
- WIDTH, 32, operand width in bits. Must be even and >= 4; an elaboration-time check rejects other values.
- STEPS, WIDTH/2+1, derived localparam (not overridable): radix-4 iterations over the (WIDTH+2)-bit extended multiplier.

Ports:
- clock  in  1  rising-edge clock
- clear_n  in  1  asynchronous active-low reset
- start  in  1  request pulse; operands sampled on the same edge
- signed_mode  in  1  1 = two's-complement operands; 0 = unsigned; sampled with start
- multiplicand  in  WIDTH  operand A (the value Y holds in the datapath)
- multiplier  in  WIDTH  operand B (the value on the bus)
- busy  out  1  high while iterating
- done  out  1  one-cycle pulse; product valid
- hi  out  WIDTH  product[2*WIDTH-1:WIDTH]
- lo  out  WIDTH  product[WIDTH-1:0]

Behaviour:
- Reset (async, clear_n=0):
  - state=IDLE, busy=0, done=0, hi=0, lo=0, step counter=0.
  - Takes effect immediately, including mid-operation; the partial product is discarded.
- States: IDLE, BUSY, DONE.
  - IDLE --start--> BUSY.
  - BUSY --last step--> DONE.
  - DONE --start--> BUSY; DONE --no start--> IDLE.
- Load edge (start sampled in IDLE or DONE):
  - Extend both operands to WIDTH+2 bits: sign-extend if signed_mode=1, zero-extend otherwise.
  - Accumulator=0; multiplier register = extended multiplier with appended Q[-1]=0; counter=STEPS.
- Each BUSY edge performs one radix-4 step:
  - Recode the low 3 multiplier bits to {0,+M,+2M,-M,-2M}.
  - Add the recoded value to the (WIDTH+3)-bit accumulator.
  - Arithmetic-shift the {accumulator, multiplier} pair right by 2.
  - Decrement the counter.
- On the edge where the counter goes 1->0:
  - state=DONE.
  - hi/lo loaded with the low 2*WIDTH bits of the final product.
- Latency:
  - start sampled at edge k -> done=1 in the cycle after edge k+STEPS.
  - WIDTH=32: 17 edges.
- done:
  - High exactly while state=DONE.
  - hi/lo hold their value until the next completion or a reset.
- busy=1 only in BUSY. start is ignored while busy; operands are not resampled.
- start in DONE: the new operation is accepted and done drops next cycle. Back-to-back throughput is STEPS+1 cycles.
- Product is exact for all inputs, including:
  - most-negative signed operands;
  - 0xFF..F × 0xFF..F unsigned.
- Overflow cannot occur; there is no flag.

Optional Feature:
- Macro: BOOTH_EARLY_TERM_EN.
- Defined:
  - In BUSY, if all remaining unconsumed multiplier-register bits (including Q[-1]) equal the extended sign, skip the remaining steps. Those steps would only add zero.
  - Finish on that edge: arithmetic-shift the pair by 2*remaining, load hi/lo, go to DONE.
  - Latency becomes data-dependent, minimum 1 BUSY edge.
  - The done/hi/lo contract is unchanged.
- Undefined: fixed STEPS latency, no variable shifter synthesised.

Decomposition:
- Shared package cpu_pkg holds:
  - mul_state_t enum {IDLE, BUSY, DONE};
  - booth_op_t enum {B_ZERO, B_PM, B_P2M, B_NM, B_N2M};
  - the ALU_MUL opcode constant (4'd11).
- One sub-module, booth_r4_recoder: combinational, 3 bits in, booth_op_t out.
- Adder, shifter and FSM stay in seq_booth_multiplier.

Test Plan:
- Unsigned, WIDTH=32, 0x00000006 × 0x00000054 -> hi=0x00000000, lo=0x000001F8; done exactly 17 edges after the start edge, one cycle wide.
- Signed, -3 (0xFFFFFFFD) × 5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- Unsigned 0xFFFFFFFF × 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. Same operands in signed mode -> hi=0, lo=1.
- Signed 0x80000000 × 0x80000000 -> hi=0x40000000, lo=0x00000000.
- Reset and re-issue:
  - Drive clear_n low at step 8 -> busy=0, done=0, hi=lo=0 immediately.
  - A new start after release computes correctly.
- Busy/done handshake:
  - start pulsed while busy -> ignored, result matches the first operands.
  - start in the DONE cycle -> second result correct.
- WIDTH=8 instance exhaustive over all 65536 pairs × both modes against a reference model. With BOOTH_EARLY_TERM_EN, 2×3 finishes in fewer than 5 BUSY edges and gives the same product.
